// File: rtl/som_pkg.sv
// Shared SOM definitions: geometry, widths, scan FSM states and distance helpers.
package som_pkg;

  localparam int N_ROW = 8;
  localparam int CH_W  = 8;
  localparam int W_W   = 3 * CH_W;
  localparam int D_W   = 11;
  localparam int IDX_W = $clog2(N_ROW);

  // Largest possible Manhattan distance between two pixels (765 for 8-bit channels).
  localparam int D_MAX = 3 * ((1 << CH_W) - 1);

  // Running minimum starts above any reachable distance so row 0 always wins first.
  localparam logic [D_W-1:0] D_INIT = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a,
                                                input logic [CH_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/vep_column_scan_if.sv
// Scan request / result / weight-write bundle between a column VEP and its neighbours.
interface vep_column_scan_if;
  import som_pkg::*;

  logic             start;
  logic [W_W-1:0]   pixel;
  logic             busy;
  logic             out_valid;
  logic [D_W-1:0]   d_out;
  logic [W_W-1:0]   w_out;
  logic [IDX_W-1:0] index_out;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [W_W-1:0]   wr_data;
  logic             wr_err;

  modport master (
    output start, pixel, wr_en, wr_addr, wr_data,
    input  busy, out_valid, d_out, w_out, index_out, wr_err
  );

  modport slave (
    input  start, pixel, wr_en, wr_addr, wr_data,
    output busy, out_valid, d_out, w_out, index_out, wr_err
  );

endinterface

// File: rtl/som_dist.sv
// Combinational Manhattan distance between two packed RGB vectors.
module som_dist
  import som_pkg::*;
(
  input  logic [W_W-1:0] i_a,
  input  logic [W_W-1:0] i_b,
  output logic [D_W-1:0] o_dist
);

  logic [CH_W-1:0] w_dr;
  logic [CH_W-1:0] w_dg;
  logic [CH_W-1:0] w_db;

  assign w_dr = abs_diff(i_a[2*CH_W +: CH_W], i_b[2*CH_W +: CH_W]);
  assign w_dg = abs_diff(i_a[1*CH_W +: CH_W], i_b[1*CH_W +: CH_W]);
  assign w_db = abs_diff(i_a[0*CH_W +: CH_W], i_b[0*CH_W +: CH_W]);

  // Three 8-bit terms cannot exceed 765, so the 11-bit sum never overflows.
  assign o_dist = {{(D_W-CH_W){1'b0}}, w_dr}
                + {{(D_W-CH_W){1'b0}}, w_dg}
                + {{(D_W-CH_W){1'b0}}, w_db};

endmodule

// File: rtl/vep_column_scan.sv
// One SOM column: 8 weight rows scanned one per cycle for the closest match to a pixel.
//
//  state  | meaning
//  S_IDLE | waiting for start; weight writes accepted
//  S_SCAN | evaluating row cnt against the latched pixel
//  S_DONE | result registers updated, out_valid high for this cycle
module vep_column_scan
  import som_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  vep_column_scan_if.slave  io_bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [W_W-1:0]   r_pix_q;
  logic [W_W-1:0]   r_weight [N_ROW];
  logic [D_W-1:0]   r_min_d;
  logic [W_W-1:0]   r_min_w;
  logic [IDX_W-1:0] r_min_i;
  logic [D_W-1:0]   r_d_out;
  logic [W_W-1:0]   r_w_out;
  logic [IDX_W-1:0] r_idx_out;
  logic             r_wr_err;

  logic [W_W-1:0]   w_cur_w;
  logic [D_W-1:0]   w_dist;
  logic             w_better;
  logic             w_last;
  logic [D_W-1:0]   w_sel_d;
  logic [W_W-1:0]   w_sel_w;
  logic [IDX_W-1:0] w_sel_i;

  assign w_cur_w  = r_weight[r_cnt];
  assign w_last   = (r_cnt == IDX_W'(N_ROW - 1));
  // Strict compare: on a tie the earlier (lower) row is kept.
  assign w_better = (w_dist < r_min_d);
  assign w_sel_d  = w_better ? w_dist  : r_min_d;
  assign w_sel_w  = w_better ? w_cur_w : r_min_w;
  assign w_sel_i  = w_better ? r_cnt   : r_min_i;

  som_dist u_dist (
    .i_a    (r_pix_q),
    .i_b    (w_cur_w),
    .o_dist (w_dist)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; start outside IDLE is simply ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.start) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_last)       w_state_nxt = S_DONE;
      S_DONE:                    w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Scan datapath: pixel latch, row counter, running minimum and published result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_pix_q   <= '0;
      r_min_d   <= D_INIT;
      r_min_w   <= '0;
      r_min_i   <= '0;
      r_d_out   <= '0;
      r_w_out   <= '0;
      r_idx_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_pix_q <= io_bus.pixel;
            r_cnt   <= '0;
            r_min_d <= D_INIT;
          end
        end
        S_SCAN: begin
          r_min_d <= w_sel_d;
          r_min_w <= w_sel_w;
          r_min_i <= w_sel_i;
          r_cnt   <= r_cnt + 1'b1;
          // Publish using the selected values so the last row is part of the result.
          if (w_last) begin
            r_d_out   <= w_sel_d;
            r_w_out   <= w_sel_w;
            r_idx_out <= w_sel_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Weight array: writes land only in IDLE, so a scan never sees a row change under it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N_ROW; k++) r_weight[k] <= '0;
    end else if (io_bus.wr_en && (r_state == S_IDLE)) begin
      r_weight[io_bus.wr_addr] <= io_bus.wr_data;
    end
  end

  // Dropped-write indication, one cycle after the rejected strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_wr_err <= 1'b0;
    else       r_wr_err <= io_bus.wr_en && (r_state != S_IDLE);
  end

  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.out_valid = (r_state == S_DONE);
  assign io_bus.d_out     = r_d_out;
  assign io_bus.w_out     = r_w_out;
  assign io_bus.index_out = r_idx_out;
  assign io_bus.wr_err    = r_wr_err;

endmodule
